fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Sits between the fetch stage and the decode stage.
- Buffers fetched instructions (instruction plus its pc+2) in a small in-order queue, so cache hit bubbles and decode stalls are absorbed without losing or duplicating instructions.
- Presents the head entry to decode with pre-split instruction fields and a sign-extended immediate.
- Flushes all contents when a taken branch redirects fetch.

Parameters:
- DEPTH, 2, number of queue entries; power of two, ≥2.
- NOP_INSTR, 16'h0000, instruction value driven to decode whenever the queue is empty.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch has a valid instruction this cycle (the cache hit signal).
- in_pc_inc2  in  16  pc+2 of the fetched instruction.
- in_instruction  in  16  fetched instruction.
- in_ready  out  1  queue can accept; fetch gates its PC enable with hit & in_ready.
- flush  in  1  taken branch / redirect (the fetch pcSrc); discards all entries.
- stall  in  1  decode/hazard stall; head entry is held.
- out_valid  out  1  head entry is valid.
- out_pc_inc2  out  16  head pc+2.
- out_instruction  out  16  head instruction, or NOP_INSTR when empty.
- out_opcode  out  4  instruction[15:12].
- out_rs  out  3  instruction[11:9].
- out_rt  out  3  instruction[8:6].
- out_rd  out  3  instruction[5:3].
- out_funct  out  3  instruction[2:0].
- out_imm_sext  out  16  instruction[5:0] sign-extended to 16 bits.
- occupancy  out  log2(DEPTH)+1  current entry count.
- bubble_count  out  16  saturating count of cycles with out_valid=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, read/write pointers=0, bubble_count=0.
  - out_valid=0, out_instruction=NOP_INSTR, out_pc_inc2=0, occupancy=0, in_ready=1.
  - Entry storage is not reset.
- Storage is a circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & ~stall & ~flush.
- in_ready = (count != DEPTH). Combinational from state only; no dependence on pop, so there is no combinational path from stall to in_ready.
- Push writes entry[wr_ptr] and increments wr_ptr.
- Pop increments rd_ptr.
- count update:
  - +1 on push only; −1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal at any count < DEPTH, including count=1.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (earliest consumption in cycle N+1). There is no same-cycle bypass from input to output.
- Output contents:
  - out_valid = (count != 0).
  - out_* fields are driven combinationally from entry[rd_ptr].
  - When empty, fields are decoded from NOP_INSTR and out_pc_inc2=0.
- Full: in_valid with in_ready=0 is ignored; fetch must hold PC and data.
- Empty with stall=1: no effect; out_valid stays 0.
- Flush:
  - At the next edge: count=0, rd_ptr=wr_ptr=0, out_valid=0.
  - Flush dominates a same-cycle push and pop; the input instruction that cycle is dropped (it is on the wrong path).
- Flush while stall=1: flush still wins; the held head entry is discarded.
- Reset mid-operation: all contents lost immediately; no partial state survives.
- bubble_count:
  - Increments at each edge where out_valid=0 at that edge.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Immediate: out_imm_sext = {{10{instr[5]}}, instr[5:0]}.

Decomposition:
- Shared package:
  - Field bit-position constants (OPC_HI/LO, RS/RT/RD/FUNCT/IMM ranges).
  - NOP_INSTR default.
  - Instruction width (16) and pc width (16) constants.
- One natural sub-module, instr_field_split: purely combinational field extraction plus sign extension, reused later by the decode stage.
- Queue control and storage stay in the top module.

Test Plan:
- Reset, then idle 5 cycles -> out_valid=0, out_instruction=16'h0000, in_ready=1, occupancy=0, bubble_count=5.
- Push 16'h1A4B (pc+2=16'h0002) with stall=0 -> next cycle out_valid=1 with:
  - out_opcode=4'h1, out_rs=3'b101, out_rt=3'b001, out_rd=3'b001, out_funct=3'b011.
  - out_imm_sext=16'h000B.
  - The following cycle, with no further push, out_valid=0.
- stall=1, push 16'h3111, 16'h3222, 16'h3333 on consecutive cycles:
  - occupancy goes 1, 2; in_ready=0 after the second push; the third is not accepted.
  - Release stall: head pops in order 3111 then 3222; occupancy decrements.
- Continuous push and pop for 8 cycles with instructions 16'h4000..16'h4007:
  - Outputs appear in order, one per cycle after a 1-cycle fill.
  - Occupancy holds at 1 across pointer wrap-around.
- Queue holding 2 entries, stall=1, flush=1 with in_valid=1 (16'h5555) -> next cycle occupancy=0, out_valid=0, and 16'h5555 is never output.
- Instruction 16'h7FE0 -> out_imm_sext=16'hFFE0.
- Force bubble_count near saturation (long idle run or bench force to 16'hFFFE) then idle 3 cycles -> stays at 16'hFFFF.
- Assert rst_n=0 mid-stream asynchronously -> outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants for the fetch/decode boundary: widths, instruction field
// positions and the default NOP encoding.
package fetch_decode_queue_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int BUB_W   = 16;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int RS_HI    = 11;
  localparam int RS_LO    = 9;
  localparam int RT_HI    = 8;
  localparam int RT_LO    = 6;
  localparam int RD_HI    = 5;
  localparam int RD_LO    = 3;
  localparam int FUNCT_HI = 2;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 5;
  localparam int IMM_LO   = 0;

  localparam int OPC_W = OPC_HI - OPC_LO + 1;
  localparam int REG_W = RS_HI - RS_LO + 1;
  localparam int FUN_W = FUNCT_HI - FUNCT_LO + 1;
  localparam int IMM_W = IMM_HI - IMM_LO + 1;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0000;

endpackage

// File: rtl/fetch_decode_queue_instr_field_split.sv
// Purely combinational instruction field extraction with a sign-extended
// 6-bit immediate; shared with the decode stage.
module instr_field_split
  import fetch_decode_queue_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   rd,
  output logic [FUN_W-1:0]   funct,
  output logic [INSTR_W-1:0] imm_sext
);

  logic signed [IMM_W-1:0] imm_field;

  assign opcode    = instr[OPC_HI:OPC_LO];
  assign rs        = instr[RS_HI:RS_LO];
  assign rt        = instr[RT_HI:RT_LO];
  assign rd        = instr[RD_HI:RD_LO];
  assign funct     = instr[FUNCT_HI:FUNCT_LO];
  assign imm_field = instr[IMM_HI:IMM_LO];
  assign imm_sext  = {{(INSTR_W-IMM_W){imm_field[IMM_W-1]}}, imm_field};

endmodule

// File: rtl/fetch_decode_queue.sv
// In-order instruction queue between fetch and decode; absorbs hit bubbles and
// decode stalls, flushes on redirect, and presents a pre-split head entry.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int                 DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [PC_W-1:0]        in_pc_inc2,
  input  logic [INSTR_W-1:0]     in_instruction,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   stall,
  output logic                   out_valid,
  output logic [PC_W-1:0]        out_pc_inc2,
  output logic [INSTR_W-1:0]     out_instruction,
  output logic [OPC_W-1:0]       out_opcode,
  output logic [REG_W-1:0]       out_rs,
  output logic [REG_W-1:0]       out_rt,
  output logic [REG_W-1:0]       out_rd,
  output logic [FUN_W-1:0]       out_funct,
  output logic [INSTR_W-1:0]     out_imm_sext,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [BUB_W-1:0]       bubble_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [BUB_W-1:0]   bubble_cnt;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head_instr;

  function automatic logic [BUB_W-1:0] sat_inc(input logic [BUB_W-1:0] v);
    return (v == {BUB_W{1'b1}}) ? v : v + BUB_W'(1);
  endfunction

  // in_ready looks only at registered count so stall never reaches it combinationally
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      bubble_cnt <= '0;
    end else begin
      if (!out_valid) bubble_cnt <= sat_inc(bubble_cnt);
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Entry storage carries no reset; out_valid masks stale contents
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instruction;
      pc_mem[wr_ptr]    <= in_pc_inc2;
    end
  end

  assign head_instr      = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
  assign out_instruction = head_instr;
  assign out_pc_inc2     = out_valid ? pc_mem[rd_ptr] : '0;
  assign occupancy       = count;
  assign bubble_count    = bubble_cnt;

  instr_field_split u_split (
    .instr    (head_instr),
    .opcode   (out_opcode),
    .rs       (out_rs),
    .rt       (out_rt),
    .rd       (out_rd),
    .funct    (out_funct),
    .imm_sext (out_imm_sext)
  );

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_pc_inc2 = '0;
  logic [15:0] in_instruction = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [15:0] out_pc_inc2;
  logic [15:0] out_instruction;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rs, out_rt, out_rd, out_funct;
  logic [15:0] out_imm_sext;
  logic [1:0]  occupancy;
  logic [15:0] bubble_count;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } ent_t;

  ent_t        q[$];
  int unsigned m_bub = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(DEPTH), .NOP_INSTR(16'h0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_pc_inc2      (in_pc_inc2),
    .in_instruction  (in_instruction),
    .in_ready        (in_ready),
    .flush           (flush),
    .stall           (stall),
    .out_valid       (out_valid),
    .out_pc_inc2     (out_pc_inc2),
    .out_instruction (out_instruction),
    .out_opcode      (out_opcode),
    .out_rs          (out_rs),
    .out_rt          (out_rt),
    .out_rd          (out_rd),
    .out_funct       (out_funct),
    .out_imm_sext    (out_imm_sext),
    .occupancy       (occupancy),
    .bubble_count    (bubble_count)
  );

  // Advance one clock; the model applies the queue rules at the same edge.
  task automatic cycle();
    bit   pu, po;
    ent_t e;
    pu = in_valid && (q.size() != DEPTH) && !flush;
    po = (q.size() != 0) && !stall && !flush;
    e.pc  = in_pc_inc2;
    e.ins = in_instruction;
    @(posedge clk);
    if (q.size() == 0 && m_bub < 65535) m_bub++;
    if (flush) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_bub = 0;
    repeat (5) cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_instruction !== 16'h0000) begin n_fail++; $display("FAIL reset_out_instruction got %h exp 0000", out_instruction); end
    n_cmp++; if (out_pc_inc2 !== 16'h0000) begin n_fail++; $display("FAIL reset_out_pc got %h exp 0000", out_pc_inc2); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    n_cmp++; if (bubble_count !== 16'd5) begin n_fail++; $display("FAIL reset_bubble got %0d exp 5", bubble_count); end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_instruction = 16'h1A4B; in_pc_inc2 = 16'h0002;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_instruction !== 16'h1A4B) begin n_fail++; $display("FAIL single_instr got %h exp 1a4b", out_instruction); end
    n_cmp++; if (out_pc_inc2 !== 16'h0002) begin n_fail++; $display("FAIL single_pc got %h exp 0002", out_pc_inc2); end
    n_cmp++; if ({out_opcode, out_rs, out_rt, out_rd, out_funct} !== {4'h1, 3'b101, 3'b001, 3'b001, 3'b011})
      begin n_fail++; $display("FAIL single_fields got %h %b %b %b %b exp 1 101 001 001 011", out_opcode, out_rs, out_rt, out_rd, out_funct); end
    n_cmp++; if (out_imm_sext !== 16'h000B) begin n_fail++; $display("FAIL single_imm got %h exp 000b", out_imm_sext); end
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_full_stall();
    logic [15:0] instrs [3];
    logic [1:0]  exp_occ [3];
    instrs[0] = 16'h3111; instrs[1] = 16'h3222; instrs[2] = 16'h3333;
    exp_occ[0] = 2'd1; exp_occ[1] = 2'd2; exp_occ[2] = 2'd2;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instruction = instrs[i]; in_pc_inc2 = 16'(2 * i + 16'h0100);
      cycle();
      n_cmp++; if (occupancy !== exp_occ[i]) begin n_fail++; $display("FAIL full_occ%0d got %0d exp %0d", i, occupancy, exp_occ[i]); end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    in_valid = 1'b0; stall = 1'b0;
    n_cmp++; if (out_instruction !== 16'h3111) begin n_fail++; $display("FAIL full_head0 got %h exp 3111", out_instruction); end
    cycle();
    n_cmp++; if (out_instruction !== 16'h3222) begin n_fail++; $display("FAIL full_head1 got %h exp 3222", out_instruction); end
    n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL full_occ_dec got %0d exp 1", occupancy); end
    cycle();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got occ %0d valid %b exp 0 0", occupancy, out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instruction = 16'h4000 + 16'(i); in_pc_inc2 = 16'h0200 + 16'(2 * i);
      cycle();
      n_cmp++; if (out_instruction !== 16'h4000 + 16'(i) || occupancy !== 2'd1)
        begin n_fail++; $display("FAIL stream%0d got %h occ %0d exp %h occ 1", i, out_instruction, occupancy, 16'h4000 + 16'(i)); end
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_flush();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instruction = 16'hA001 + 16'(i); in_pc_inc2 = 16'h0300 + 16'(2 * i);
      cycle();
    end
    in_valid = 1'b1; in_instruction = 16'h5555; flush = 1'b1;
    cycle();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got occ %0d valid %b exp 0 0", occupancy, out_valid); end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if (out_instruction === 16'h5555 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak%0d got %h valid %b exp 0000 0", i, out_instruction, out_valid); end
    end
  endtask

  task automatic test_imm();
    in_valid = 1'b1; in_instruction = 16'h7FE0; in_pc_inc2 = 16'h0400;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (out_imm_sext !== 16'hFFE0) begin n_fail++; $display("FAIL imm_neg got %h exp ffe0", out_imm_sext); end
    cycle();
  endtask

  task automatic test_bubble_sat();
    idle_inputs();
    force dut.bubble_cnt = 16'hFFFE;
    #1;
    release dut.bubble_cnt;
    m_bub = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if (bubble_count !== 16'hFFFF) begin n_fail++; $display("FAIL bubble_sat%0d got %h exp ffff", i, bubble_count); end
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instruction = 16'h6100 + 16'(i); in_pc_inc2 = 16'h0500 + 16'(2 * i);
      cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL async_rst_ctrl got valid %b occ %0d ready %b exp 0 0 1", out_valid, occupancy, in_ready); end
    n_cmp++; if (out_instruction !== 16'h0000 || out_pc_inc2 !== 16'h0000 || bubble_count !== 16'h0000)
      begin n_fail++; $display("FAIL async_rst_data got %h %h %h exp 0000 0000 0000", out_instruction, out_pc_inc2, bubble_count); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_bub = 0;
  endtask

  task automatic test_random();
    logic [15:0] e_ins, e_pc, e_imm;
    int          v;
    for (int n = 0; n < 300; n++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 15) == 0);
      in_instruction = 16'($urandom);
      in_pc_inc2     = 16'($urandom);
      cycle();
      e_ins = (q.size() != 0) ? q[0].ins : 16'h0000;
      e_pc  = (q.size() != 0) ? q[0].pc  : 16'h0000;
      v = int'(e_ins % 64);
      if (v >= 32) v = v - 64;
      e_imm = 16'(v);
      n_cmp++; if (out_valid !== (q.size() != 0) || occupancy !== 2'(q.size()) || in_ready !== (q.size() != DEPTH))
        begin n_fail++; $display("FAIL rnd%0d_ctrl got valid %b occ %0d ready %b exp occ %0d", n, out_valid, occupancy, in_ready, q.size()); end
      n_cmp++; if (out_instruction !== e_ins || out_pc_inc2 !== e_pc)
        begin n_fail++; $display("FAIL rnd%0d_head got %h/%h exp %h/%h", n, out_instruction, out_pc_inc2, e_ins, e_pc); end
      n_cmp++; if (out_opcode !== 4'(e_ins / 4096) || out_rs !== 3'((e_ins / 512) % 8) || out_rt !== 3'((e_ins / 64) % 8)
                   || out_rd !== 3'((e_ins / 8) % 8) || out_funct !== 3'(e_ins % 8) || out_imm_sext !== e_imm)
        begin n_fail++; $display("FAIL rnd%0d_fields got %h %h %h %h %h %h for instr %h", n, out_opcode, out_rs, out_rt, out_rd, out_funct, out_imm_sext, e_ins); end
      n_cmp++; if (bubble_count !== 16'(m_bub))
        begin n_fail++; $display("FAIL rnd%0d_bubble got %0d exp %0d", n, bubble_count, m_bub); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full_stall();
    test_stream();
    test_flush();
    test_imm();
    test_bubble_sat();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
